// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and bus width shared by the GPIO controller
package gpio_pkg;
  localparam int GPIO_BUS_W = 32;
  localparam logic [5:0] GPIO_OFF_OUT  = 6'h00;
  localparam logic [5:0] GPIO_OFF_DIR  = 6'h04;
  localparam logic [5:0] GPIO_OFF_IN   = 6'h08;
  localparam logic [5:0] GPIO_OFF_SET  = 6'h0C;
  localparam logic [5:0] GPIO_OFF_CLR  = 6'h10;
  localparam logic [5:0] GPIO_OFF_TGL  = 6'h14;
  localparam logic [5:0] GPIO_OFF_IER  = 6'h18;
  localparam logic [5:0] GPIO_OFF_IEF  = 6'h1C;
  localparam logic [5:0] GPIO_OFF_PEND = 6'h20;
endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: pin synchronizer chain, prev register and input-only rise/fall detect
module gpio_in_sync #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] in_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign in_q = sync[SYNC_STAGES-1];
  assign rise = in_q & ~prev & ~dir;
  assign fall = ~in_q & prev & ~dir;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with atomic set/clr/tgl, synced inputs and W1C edge interrupts
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic                  bus_we,
  input  logic [5:0]            bus_addr,
  input  logic [GPIO_BUS_W-1:0] bus_wdata,
  output logic [GPIO_BUS_W-1:0] bus_rdata,
  input  logic [WIDTH-1:0]      gpio_i,
  output logic [WIDTH-1:0]      gpio_o,
  output logic [WIDTH-1:0]      gpio_oe,
  output logic                  irq
);
  localparam int ARM = SYNC_STAGES + 1;
  localparam int CW = $clog2(ARM + 1);
  logic [WIDTH-1:0] wd, out_r, dir_r, ie_r, ie_f, pend, in_q, rise, fall, out_n, w1c;
  logic [CW-1:0] cnt;
  logic [5:0] a;
  logic wr, rd, armed, unused;
  assign a = {bus_addr[5:2], 2'b00};
  assign wd = bus_wdata[WIDTH-1:0];
  assign wr = bus_sel & bus_we;
  assign rd = bus_sel & ~bus_we;
  assign armed = cnt == CW'(ARM);
  assign unused = ^{bus_addr[1:0], bus_wdata};
  gpio_in_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .gpio_i(gpio_i), .dir(dir_r),
    .in_q(in_q), .rise(rise), .fall(fall)
  );
  always_comb begin
    out_n = !wr ? out_r :
            a == GPIO_OFF_OUT ? wd :
            a == GPIO_OFF_SET ? out_r | wd :
            a == GPIO_OFF_CLR ? out_r & ~wd :
            a == GPIO_OFF_TGL ? out_r ^ wd : out_r;
    w1c = (wr && a == GPIO_OFF_PEND) ? wd : '0;
    bus_rdata = !rd ? '0 :
                a == GPIO_OFF_OUT  ? GPIO_BUS_W'(out_r) :
                a == GPIO_OFF_DIR  ? GPIO_BUS_W'(dir_r) :
                a == GPIO_OFF_IN   ? GPIO_BUS_W'(in_q) :
                a == GPIO_OFF_IER  ? GPIO_BUS_W'(ie_r) :
                a == GPIO_OFF_IEF  ? GPIO_BUS_W'(ie_f) :
                a == GPIO_OFF_PEND ? GPIO_BUS_W'(pend) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r <= '0;
      dir_r <= '0;
      ie_r  <= '0;
      ie_f  <= '0;
      pend  <= '0;
      cnt   <= '0;
    end else begin
      out_r <= out_n;
      if (wr && a == GPIO_OFF_DIR) dir_r <= wd;
      if (wr && a == GPIO_OFF_IER) ie_r <= wd;
      if (wr && a == GPIO_OFF_IEF) ie_f <= wd;
      pend <= (pend & ~w1c) | ({WIDTH{armed}} & ((rise & ie_r) | (fall & ie_f)));
      if (!armed) cnt <= cnt + CW'(1);
    end
  end
  assign gpio_o = out_r;
  assign gpio_oe = dir_r;
  assign irq = |pend;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scoreboard bench for gpio_ctrl
module tb_gpio_ctrl;
  typedef struct {
    string tag;
    logic [31:0] val;
  } exp_t;
  logic clk = 0, rst_n = 0, bus_sel = 0, bus_we = 0, irq;
  logic [5:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic [15:0] pins = '0, gpio_o, gpio_oe;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  gpio_ctrl #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .gpio_i(pins), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask
  task automatic check(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic wr(input logic [5:0] ad, input logic [31:0] d);
    bus_sel = 1;
    bus_we = 1;
    bus_addr = ad;
    bus_wdata = d;
    step();
    bus_sel = 0;
    bus_we = 0;
    bus_wdata = '0;
  endtask
  task automatic rd_chk(input logic [5:0] ad, input string tag, input logic [31:0] e);
    push(tag, e);
    bus_sel = 1;
    bus_we = 0;
    bus_addr = ad;
    #1;
    check(bus_rdata);
    bus_sel = 0;
  endtask
  initial begin
    step(2);
    rst_n = 1;
    for (int i = 0; i <= 9; i++) rd_chk(6'(i * 4), $sformatf("rst_rd_%0h", i * 4), 0);
    push("rst_oe", 0);
    check(32'(gpio_oe));
    push("rst_irq", 0);
    check(32'(irq));
    push("no_rd_when_unsel", 0);
    bus_addr = 6'h00;
    #1 check(bus_rdata);
    wr(6'h04, 32'h0000_00FF);
    push("dir_oe", 32'h00FF);
    wr(6'h00, 32'hFFFF_1234);
    push("out_o", 32'h1234);
    check(32'(gpio_oe));
    check(32'(gpio_o));
    rd_chk(6'h00, "out_rb", 32'h1234);
    rd_chk(6'h06, "dir_rb_lowbits_ignored", 32'h00FF);
    wr(6'h00, 32'h00F0);
    wr(6'h0C, 32'h000F);
    push("out_set", 32'h00FF);
    check(32'(gpio_o));
    wr(6'h10, 32'h00F0);
    push("out_clr", 32'h000F);
    check(32'(gpio_o));
    wr(6'h14, 32'hFFFF);
    push("out_tgl", 32'hFFF0);
    check(32'(gpio_o));
    rd_chk(6'h0C, "set_reads_0", 0);
    wr(6'h24, 32'hFFFF);
    rd_chk(6'h00, "unmapped_wr_ignored", 32'hFFF0);
    wr(6'h04, 0);
    wr(6'h08, 32'hFFFF);
    rd_chk(6'h08, "in_wr_ignored", 0);
    pins = 16'h5555;
    rd_chk(6'h08, "in_before_k", 0);
    step();
    rd_chk(6'h08, "in_after_k", 0);
    step();
    rd_chk(6'h08, "in_after_k1", 32'h5555);
    pins = 16'h0002;
    step(4);
    rd_chk(6'h20, "pend_no_ie", 0);
    wr(6'h18, 32'h0001);
    wr(6'h1C, 32'h0002);
    pins = 16'h0003;
    step(2);
    rd_chk(6'h20, "pend_after_k1", 0);
    step();
    rd_chk(6'h20, "pend_rise0", 32'h0001);
    push("irq_rise0", 1);
    check(32'(irq));
    pins = 16'h0001;
    step(3);
    rd_chk(6'h20, "pend_fall1", 32'h0003);
    wr(6'h20, 32'h0001);
    rd_chk(6'h20, "pend_w1c", 32'h0002);
    pins = 16'h0005;
    step(3);
    rd_chk(6'h20, "pend_unenabled", 32'h0002);
    wr(6'h20, 32'h0003);
    pins = 16'h0004;
    step(3);
    rd_chk(6'h20, "pend_cleared", 0);
    push("irq_cleared", 0);
    check(32'(irq));
    pins = 16'h0005;
    step(2);
    wr(6'h20, 32'h0001);
    rd_chk(6'h20, "pend_set_wins", 32'h0001);
    wr(6'h18, 0);
    rd_chk(6'h20, "pend_kept_on_ie_clr", 32'h0001);
    wr(6'h18, 32'h0001);
    wr(6'h04, 32'h0003);
    wr(6'h20, 32'hFFFF);
    pins = 16'h0006;
    step(3);
    pins = 16'h0005;
    step(3);
    rd_chk(6'h20, "pend_out_pins", 0);
    rd_chk(6'h08, "in_out_pins", 32'h0005);
    pins = 16'hFFFF;
    rst_n = 0;
    step();
    rst_n = 1;
    wr(6'h18, 32'hFFFF);
    step(6);
    rd_chk(6'h20, "arm_pend", 0);
    push("arm_irq", 0);
    check(32'(irq));
    rd_chk(6'h04, "arm_dir", 0);
    pins = 16'h0000;
    step(3);
    pins = 16'h0003;
    wr(6'h00, 32'hABCD);
    step(3);
    rd_chk(6'h20, "pre_rst_pend", 32'h0003);
    push("pre_rst_irq", 1);
    check(32'(irq));
    rst_n = 0;
    step();
    push("mid_rst_irq", 0);
    check(32'(irq));
    push("mid_rst_o", 0);
    check(32'(gpio_o));
    rst_n = 1;
    rd_chk(6'h20, "mid_rst_pend", 0);
    rd_chk(6'h18, "mid_rst_ier", 0);
    rd_chk(6'h08, "mid_rst_in", 0);
    step(6);
    rd_chk(6'h20, "post_rst_pend", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Memory-mapped controller for the GPIO port of the single-cycle RISC-V core. It sits on the CPU data bus next to RAM and gives software control of the port:
- output data and per-pin direction, with atomic set/clear/toggle;
- synchronized input sampling;
- per-pin rising/falling edge interrupts with write-1-to-clear pending bits.

The top level owns the tristate: `gpioA_io[i] = gpio_oe[i] ? gpio_o[i] : 'z`, and `gpio_i = gpioA_io`.

## Interface
Parameters:
- `WIDTH`, 16, number of GPIO pins (1..32)
- `SYNC_STAGES`, 2, input synchronizer depth (≥2)

Ports:
- `clk`  in  1  system clock; everything is clocked on its rising edge
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `bus_sel`  in  1  peripheral selected by the address decoder this cycle
- `bus_we`  in  1  1 = write, 0 = read (qualified by `bus_sel`)
- `bus_addr`  in  6  byte offset; bits [1:0] are ignored
- `bus_wdata`  in  32  write data; bits above `WIDTH` are ignored
- `bus_rdata`  out  32  read data, combinational; 0 when not a read
- `gpio_i`  in  `WIDTH`  raw pin levels (asynchronous)
- `gpio_o`  out  `WIDTH`  output data register
- `gpio_oe`  out  `WIDTH`  direction register, 1 = drive pin
- `irq`  out  1  OR of all pending bits

## Operation
Register map (word offsets; unused upper bits read 0):
- 0x00 `OUT`: RW, output data.
- 0x04 `DIR`: RW, 1 = output.
- 0x08 `IN`: RO, synchronized pin levels. Reflects pins in both directions.
- 0x0C `OUT_SET`: WO. `OUT |= wdata`.
- 0x10 `OUT_CLR`: WO. `OUT &= ~wdata`.
- 0x14 `OUT_TGL`: WO. `OUT ^= wdata`.
- 0x18 `IE_RISE`: RW, rising-edge interrupt enable per pin.
- 0x1C `IE_FALL`: RW, falling-edge interrupt enable per pin.
- 0x20 `IRQ_PEND`: RW1C. Writing 1 clears the bit; writing 0 has no effect.

Read and write rules:
- Write-only registers read as 0.
- Unmapped offsets read 0; writes to them are ignored.
- Writes to `IN` are ignored.

Input path:
- `gpio_i` passes through `SYNC_STAGES` flops. The last stage is `IN`.
- A `prev` register holds `IN` delayed by one cycle.
- `rise = IN & ~prev & ~DIR`; `fall = ~IN & prev & ~DIR`. Pins configured as outputs never raise edges.

Pending update, per bit, each cycle:
- `pend_next = (pend & ~w1c) | (rise & IE_RISE) | (fall & IE_FALL)`.
- When an edge and a W1C hit the same bit in the same cycle, the set wins.
- Clearing an enable bit does not clear an already-pending bit.

Post-reset arming:
- A small counter suppresses edge detection for the first `SYNC_STAGES`+1 cycles after reset release.
- This prevents a pin that is high at reset from producing a false rising edge.
- Once armed, the controller stays armed until the next reset.

## Timing
- Reset (`rst_n`=0 at a rising edge) clears:
  - `OUT`, `DIR`, `IE_RISE`, `IE_FALL`, `IRQ_PEND`, all synchronizer flops, `prev`, and the arm counter;
  - therefore `gpio_o`=0, `gpio_oe`=0 (all inputs), `irq`=0.
- Reset asserted mid-operation discards any pending state at that edge, with no partial updates.
- Writes (`bus_sel`&`bus_we`) take effect at the clock edge ending the bus cycle. `gpio_o`, `gpio_oe` and register reads reflect the new value from the next cycle.
- Reads have zero latency: `bus_rdata` is a combinational decode of the current register state, as the single-cycle core requires.
- A write to `DIR` and an edge on the same pin in the same cycle: detection uses the pre-write `DIR`.
- Input latency, for a pin that changes before edge k:
  - `IN` is updated after edge k+`SYNC_STAGES`-1.
  - `IRQ_PEND` and `irq` are set after edge k+`SYNC_STAGES`.
  - With the default depth this is 3 edges.
- `irq` is a registered-equivalent signal (an OR of flops) and is glitch-free.

## Structure
- Package `gpio_pkg` holds:
  - the register offset localparams (`GPIO_OFF_OUT` … `GPIO_OFF_PEND`);
  - the bus data width constant (32).
- Sub-module `gpio_in_sync` (synchronizer chain, `prev` register, rise/fall outputs; parameterized by `WIDTH` and `SYNC_STAGES`).
  - It is instantiated once.
  - The register file, the pending logic and the arm counter stay in `gpio_ctrl`.

## Test plan
- Reset and basic write/read:
  - After reset, all reads return 0, `gpio_oe`=0 and `irq`=0.
  - Write `DIR`=0x00FF and `OUT`=0x1234 → `gpio_oe`=0x00FF and `gpio_o`=0x1234 the next cycle; read-back matches.
- Atomic set/clear/toggle:
  - Start from `OUT`=0x00F0.
  - `OUT_SET` 0x000F → 0x00FF; `OUT_CLR` 0x00F0 → 0x000F; `OUT_TGL` 0xFFFF → 0xFFF0.
- Input sync latency:
  - `DIR`=0; drive `gpio_i` from 0x0000 to 0x5555 before edge k.
  - `IN` reads 0x0000 through edge k and 0x5555 after edge k+1.
- Edge interrupts:
  - `IE_RISE`=0x0001 and `IE_FALL`=0x0002.
  - Raise pin 0 → `IRQ_PEND`=0x0001 and `irq`=1 after edge k+2.
  - Lower pin 1 → `IRQ_PEND`=0x0003.
  - W1C 0x0001 → `IRQ_PEND`=0x0002.
  - A rising edge on pin 2, which is not enabled, sets nothing.
- W1C vs. new edge collision:
  - Time a W1C 0x0001 into the same cycle that pin 0 generates its pending set → `IRQ_PEND`[0] stays 1.
  - Edges on pins with `DIR`=1 never set pending.
- Reset arming and mid-operation reset:
  - Hold `gpio_i`=0xFFFF with `IE_RISE`=0xFFFF written right after reset → `IRQ_PEND` stays 0.
  - With pending=0x0003, pulse `rst_n` low for one cycle → all registers return to 0 and `irq` drops after that edge.
